// File: rtl/synapse_weight_arbiter.sv
// Arbitrates the single-port synaptic weight RAM between round-robin lookup readers
// and the config write path, with tagged one-cycle-later read responses and range checks.
module synapse_weight_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int NUM_SYNAPSES  = 214,
  parameter int ADDR_W        = 8,
  parameter int WEIGHT_W      = 16,
  parameter int WR_MAX_CONSEC = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      hold,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [WEIGHT_W-1:0]       rsp_data,
  output logic                      rsp_err,
  input  logic                      cfg_wr_valid,
  input  logic [ADDR_W-1:0]         cfg_wr_addr,
  input  logic [WEIGHT_W-1:0]       cfg_wr_data,
  output logic                      cfg_wr_ready,
  output logic                      cfg_wr_err,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [WEIGHT_W-1:0]       mem_wdata,
  input  logic [WEIGHT_W-1:0]       mem_rdata,
  output logic [15:0]               err_count,
  output logic                      busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW    = $clog2(WR_MAX_CONSEC + 1);
  localparam logic [ADDR_W:0]  SYN_LIMIT  = (ADDR_W + 1)'(NUM_SYNAPSES);
  localparam logic [CW-1:0]    CONSEC_MAX = CW'(WR_MAX_CONSEC);
  localparam logic [PTR_W:0]   NUM_REQ_W  = (PTR_W + 1)'(NUM_REQ);

  logic [PTR_W-1:0]   rr_ptr_reg;
  logic [CW-1:0]      consec_wr_reg;
  logic [NUM_REQ-1:0] rsp_valid_reg;
  logic               rsp_err_reg;
  logic               cfg_wr_err_reg;
  logic [15:0]        err_count_reg;

  logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
  logic [NUM_REQ-1:0] addr_oor;
  logic [NUM_REQ-1:0] rd_onehot;

  logic               grant_en;
  logic               any_req;
  logic               wr_grant;
  logic               rd_grant;
  logic               rd_found;
  logic [PTR_W-1:0]   rd_sel;
  logic [PTR_W-1:0]   rr_ptr_next;
  logic               rd_oor;
  logic               wr_oor;
  logic               oor_grant;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign addr_oor[gi]  = ({1'b0, addr_arr[gi]} >= SYN_LIMIT);
      assign rd_onehot[gi] = rd_grant && (rd_sel == PTR_W'(gi));
    end
  endgenerate

  assign grant_en = !rst && !hold;
  assign any_req  = |req_valid;
  // Config writes win unless they have already starved a pending reader for the full budget.
  assign wr_grant = grant_en && cfg_wr_valid && !((consec_wr_reg == CONSEC_MAX) && any_req);
  assign rd_grant = grant_en && any_req && !wr_grant;

  always_comb begin
    logic [PTR_W:0] idx;
    rd_found = 1'b0;
    rd_sel   = '0;
    idx      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr_reg} + (PTR_W + 1)'(k);
      if (idx >= NUM_REQ_W) idx = idx - NUM_REQ_W;
      if (!rd_found && req_valid[idx[PTR_W-1:0]]) begin
        rd_found = 1'b1;
        rd_sel   = idx[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    logic [PTR_W:0] nxt;
    nxt = {1'b0, rd_sel} + (PTR_W + 1)'(1);
    if (nxt >= NUM_REQ_W) nxt = '0;
    rr_ptr_next = nxt[PTR_W-1:0];
  end

  assign rd_oor    = addr_oor[rd_sel];
  assign wr_oor    = ({1'b0, cfg_wr_addr} >= SYN_LIMIT);
  assign oor_grant = (rd_grant && rd_oor) || (wr_grant && wr_oor);

  assign req_ready    = rd_onehot;
  assign cfg_wr_ready = wr_grant;

  // Out-of-range grants are still accepted but never touch the RAM.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (wr_grant && !wr_oor) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = cfg_wr_addr;
      mem_wdata = cfg_wr_data;
    end else if (rd_grant && !rd_oor) begin
      mem_en   = 1'b1;
      mem_addr = addr_arr[rd_sel];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg     <= '0;
      consec_wr_reg  <= '0;
      rsp_valid_reg  <= '0;
      rsp_err_reg    <= 1'b0;
      cfg_wr_err_reg <= 1'b0;
      err_count_reg  <= '0;
    end else begin
      rsp_valid_reg  <= rd_onehot;
      rsp_err_reg    <= rd_grant && rd_oor;
      cfg_wr_err_reg <= wr_grant && wr_oor;
      if (rd_grant) rr_ptr_reg <= rr_ptr_next;
      if (rd_grant || !cfg_wr_valid) consec_wr_reg <= '0;
      else if (wr_grant && (consec_wr_reg != CONSEC_MAX)) consec_wr_reg <= consec_wr_reg + 1'b1;
      if (oor_grant && (err_count_reg != 16'hFFFF)) err_count_reg <= err_count_reg + 16'd1;
    end
  end

  // Outputs are forced to their idle values while reset is held, dropping any in-flight response.
  assign rsp_valid  = rst ? '0 : rsp_valid_reg;
  assign rsp_err    = !rst && rsp_err_reg && (|rsp_valid_reg);
  assign rsp_data   = (!rst && (|rsp_valid_reg) && !rsp_err_reg) ? mem_rdata : '0;
  assign cfg_wr_err = !rst && cfg_wr_err_reg;
  assign err_count  = rst ? 16'd0 : err_count_reg;
  assign busy       = !rst && (any_req || cfg_wr_valid || (|rsp_valid_reg));

endmodule

// File: tb/tb_synapse_weight_arbiter.sv
// Table-driven bench for synapse_weight_arbiter with a registered-read RAM model.
module tb_synapse_weight_arbiter;

  logic        clk = 1'b0;
  logic        rst, hold;
  logic [3:0]  req_valid, req_ready, rsp_valid;
  logic [31:0] req_addr;
  logic [15:0] rsp_data, cfg_wr_data, mem_wdata, mem_rdata, err_count;
  logic        rsp_err, cfg_wr_valid, cfg_wr_ready, cfg_wr_err, mem_en, mem_we, busy;
  logic [7:0]  cfg_wr_addr, mem_addr;
  logic [15:0] ram [256];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  synapse_weight_arbiter dut (
    .clk(clk), .rst(rst), .hold(hold),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .cfg_wr_valid(cfg_wr_valid), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
    .cfg_wr_ready(cfg_wr_ready), .cfg_wr_err(cfg_wr_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .err_count(err_count), .busy(busy)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  typedef struct {
    logic rst; logic hold; logic [3:0] rv; logic [31:0] ra;
    logic wv; logic [7:0] wa; logic [15:0] wd;
    logic [3:0] e_rdy; logic e_wrdy; logic e_en; logic e_we; logic [7:0] e_addr; logic [15:0] e_wdata;
    logic [3:0] e_rspv; logic [15:0] e_rdata; logic e_rerr; logic e_wrerr; logic [15:0] e_errc; logic e_busy;
  } vec_t;

  vec_t vecs [31];

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=%h required=%h", name, row, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic h, input logic [3:0] rv, input logic [31:0] ra,
                       input logic wv, input logic [7:0] wa, input logic [15:0] wd);
    @(negedge clk);
    rst = r; hold = h; req_valid = rv; req_addr = ra;
    cfg_wr_valid = wv; cfg_wr_addr = wa; cfg_wr_data = wd;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 16'hA000 + 16'(i);
    ram[5] = 16'h1234;
    mem_rdata = 16'h0;
    rst = 1'b1; hold = 1'b0; req_valid = 4'h0; req_addr = 32'h0;
    cfg_wr_valid = 1'b0; cfg_wr_addr = 8'h0; cfg_wr_data = 16'h0;

    // rst hold rv ra wv wa wd | rdy wrdy en we addr wdata | rspv rdata rerr wrerr errc busy
    vecs[0]  = '{1'b1,1'b0,4'h0,32'h0,1'b0,8'h0,16'h0,       4'h0,1'b0,1'b0,1'b0,8'd0,16'h0,    4'h0,16'h0,1'b0,1'b0,16'd0,1'b0};
    vecs[1]  = '{1'b0,1'b0,4'h4,32'h00050000,1'b0,8'h0,16'h0,4'h4,1'b0,1'b1,1'b0,8'd5,16'h0,    4'h0,16'h0,1'b0,1'b0,16'd0,1'b1};
    vecs[2]  = '{1'b0,1'b0,4'h0,32'h0,1'b0,8'h0,16'h0,       4'h0,1'b0,1'b0,1'b0,8'd0,16'h0,    4'h4,16'h1234,1'b0,1'b0,16'd0,1'b1};
    vecs[3]  = '{1'b1,1'b0,4'h0,32'h0,1'b0,8'h0,16'h0,       4'h0,1'b0,1'b0,1'b0,8'd0,16'h0,    4'h0,16'h0,1'b0,1'b0,16'd0,1'b0};
    vecs[4]  = '{1'b0,1'b0,4'hF,32'h17161514,1'b0,8'h0,16'h0,4'h1,1'b0,1'b1,1'b0,8'd20,16'h0,   4'h0,16'h0,1'b0,1'b0,16'd0,1'b1};
    vecs[5]  = '{1'b0,1'b0,4'hF,32'h17161514,1'b0,8'h0,16'h0,4'h2,1'b0,1'b1,1'b0,8'd21,16'h0,   4'h1,16'hA014,1'b0,1'b0,16'd0,1'b1};
    vecs[6]  = '{1'b0,1'b0,4'hF,32'h17161514,1'b0,8'h0,16'h0,4'h4,1'b0,1'b1,1'b0,8'd22,16'h0,   4'h2,16'hA015,1'b0,1'b0,16'd0,1'b1};
    vecs[7]  = '{1'b0,1'b0,4'hF,32'h17161514,1'b0,8'h0,16'h0,4'h8,1'b0,1'b1,1'b0,8'd23,16'h0,   4'h4,16'hA016,1'b0,1'b0,16'd0,1'b1};
    vecs[8]  = '{1'b0,1'b0,4'hF,32'h17161514,1'b0,8'h0,16'h0,4'h1,1'b0,1'b1,1'b0,8'd20,16'h0,   4'h8,16'hA017,1'b0,1'b0,16'd0,1'b1};
    vecs[9]  = '{1'b0,1'b0,4'hF,32'h17161514,1'b0,8'h0,16'h0,4'h2,1'b0,1'b1,1'b0,8'd21,16'h0,   4'h1,16'hA014,1'b0,1'b0,16'd0,1'b1};
    vecs[10] = '{1'b0,1'b0,4'hF,32'h17161514,1'b0,8'h0,16'h0,4'h4,1'b0,1'b1,1'b0,8'd22,16'h0,   4'h2,16'hA015,1'b0,1'b0,16'd0,1'b1};
    vecs[11] = '{1'b0,1'b0,4'hF,32'h17161514,1'b0,8'h0,16'h0,4'h8,1'b0,1'b1,1'b0,8'd23,16'h0,   4'h4,16'hA016,1'b0,1'b0,16'd0,1'b1};
    vecs[12] = '{1'b0,1'b1,4'hF,32'h17161514,1'b0,8'h0,16'h0,4'h0,1'b0,1'b0,1'b0,8'd0,16'h0,    4'h8,16'hA017,1'b0,1'b0,16'd0,1'b1};
    vecs[13] = '{1'b0,1'b1,4'hF,32'h17161514,1'b0,8'h0,16'h0,4'h0,1'b0,1'b0,1'b0,8'd0,16'h0,    4'h0,16'h0,1'b0,1'b0,16'd0,1'b1};
    vecs[14] = '{1'b0,1'b0,4'hF,32'h17161514,1'b0,8'h0,16'h0,4'h1,1'b0,1'b1,1'b0,8'd20,16'h0,   4'h0,16'h0,1'b0,1'b0,16'd0,1'b1};
    vecs[15] = '{1'b1,1'b0,4'h0,32'h0,1'b0,8'h0,16'h0,       4'h0,1'b0,1'b0,1'b0,8'd0,16'h0,    4'h0,16'h0,1'b0,1'b0,16'd0,1'b0};
    vecs[16] = '{1'b0,1'b0,4'h0,32'h0,1'b0,8'h0,16'h0,       4'h0,1'b0,1'b0,1'b0,8'd0,16'h0,    4'h0,16'h0,1'b0,1'b0,16'd0,1'b0};
    vecs[17] = '{1'b0,1'b0,4'h1,32'h28,1'b1,8'd30,16'h5555,  4'h0,1'b1,1'b1,1'b1,8'd30,16'h5555,4'h0,16'h0,1'b0,1'b0,16'd0,1'b1};
    vecs[18] = '{1'b0,1'b0,4'h1,32'h28,1'b1,8'd30,16'h5555,  4'h0,1'b1,1'b1,1'b1,8'd30,16'h5555,4'h0,16'h0,1'b0,1'b0,16'd0,1'b1};
    vecs[19] = '{1'b0,1'b0,4'h1,32'h28,1'b1,8'd30,16'h5555,  4'h0,1'b1,1'b1,1'b1,8'd30,16'h5555,4'h0,16'h0,1'b0,1'b0,16'd0,1'b1};
    vecs[20] = '{1'b0,1'b0,4'h1,32'h28,1'b1,8'd30,16'h5555,  4'h0,1'b1,1'b1,1'b1,8'd30,16'h5555,4'h0,16'h0,1'b0,1'b0,16'd0,1'b1};
    vecs[21] = '{1'b0,1'b0,4'h1,32'h28,1'b1,8'd30,16'h5555,  4'h1,1'b0,1'b1,1'b0,8'd40,16'h0,   4'h0,16'h0,1'b0,1'b0,16'd0,1'b1};
    vecs[22] = '{1'b0,1'b0,4'h1,32'h28,1'b1,8'd30,16'h5555,  4'h0,1'b1,1'b1,1'b1,8'd30,16'h5555,4'h1,16'hA028,1'b0,1'b0,16'd0,1'b1};
    vecs[23] = '{1'b0,1'b0,4'h0,32'h0,1'b0,8'h0,16'h0,       4'h0,1'b0,1'b0,1'b0,8'd0,16'h0,    4'h0,16'h0,1'b0,1'b0,16'd0,1'b0};
    vecs[24] = '{1'b0,1'b0,4'h0,32'h0,1'b1,8'd10,16'hBEEF,   4'h0,1'b1,1'b1,1'b1,8'd10,16'hBEEF,4'h0,16'h0,1'b0,1'b0,16'd0,1'b1};
    vecs[25] = '{1'b0,1'b0,4'h2,32'h00000A00,1'b0,8'h0,16'h0,4'h2,1'b0,1'b1,1'b0,8'd10,16'h0,   4'h0,16'h0,1'b0,1'b0,16'd0,1'b1};
    vecs[26] = '{1'b0,1'b0,4'h0,32'h0,1'b0,8'h0,16'h0,       4'h0,1'b0,1'b0,1'b0,8'd0,16'h0,    4'h2,16'hBEEF,1'b0,1'b0,16'd0,1'b1};
    vecs[27] = '{1'b0,1'b0,4'h4,32'h00D60000,1'b0,8'h0,16'h0,4'h4,1'b0,1'b0,1'b0,8'd0,16'h0,    4'h0,16'h0,1'b0,1'b0,16'd0,1'b1};
    vecs[28] = '{1'b0,1'b0,4'h0,32'h0,1'b1,8'hFF,16'h1111,   4'h0,1'b1,1'b0,1'b0,8'd0,16'h0,    4'h4,16'h0,1'b1,1'b0,16'd1,1'b1};
    vecs[29] = '{1'b0,1'b0,4'h0,32'h0,1'b0,8'h0,16'h0,       4'h0,1'b0,1'b0,1'b0,8'd0,16'h0,    4'h0,16'h0,1'b0,1'b1,16'd2,1'b0};
    vecs[30] = '{1'b0,1'b0,4'h0,32'h0,1'b0,8'h0,16'h0,       4'h0,1'b0,1'b0,1'b0,8'd0,16'h0,    4'h0,16'h0,1'b0,1'b0,16'd2,1'b0};

    @(posedge clk);
    @(posedge clk);

    for (int r = 0; r < 31; r++) begin
      drive(vecs[r].rst, vecs[r].hold, vecs[r].rv, vecs[r].ra, vecs[r].wv, vecs[r].wa, vecs[r].wd);
      $display("row %0d: rdy=%h wrdy=%b en=%b we=%b addr=%0d rspv=%h rdata=%h rerr=%b wrerr=%b errc=%0d busy=%b",
               r, req_ready, cfg_wr_ready, mem_en, mem_we, mem_addr, rsp_valid, rsp_data,
               rsp_err, cfg_wr_err, err_count, busy);
      chk("req_ready",    r, 32'(req_ready),    32'(vecs[r].e_rdy));
      chk("cfg_wr_ready", r, 32'(cfg_wr_ready), 32'(vecs[r].e_wrdy));
      chk("mem_en",       r, 32'(mem_en),       32'(vecs[r].e_en));
      chk("mem_we",       r, 32'(mem_we),       32'(vecs[r].e_we));
      chk("mem_addr",     r, 32'(mem_addr),     32'(vecs[r].e_addr));
      chk("mem_wdata",    r, 32'(mem_wdata),    32'(vecs[r].e_wdata));
      chk("rsp_valid",    r, 32'(rsp_valid),    32'(vecs[r].e_rspv));
      chk("rsp_data",     r, 32'(rsp_data),     32'(vecs[r].e_rdata));
      chk("rsp_err",      r, 32'(rsp_err),      32'(vecs[r].e_rerr));
      chk("cfg_wr_err",   r, 32'(cfg_wr_err),   32'(vecs[r].e_wrerr));
      chk("err_count",    r, 32'(err_count),    32'(vecs[r].e_errc));
      chk("busy",         r, 32'(busy),         32'(vecs[r].e_busy));
    end

    // Write-only stream saturates the write budget; a reader appearing afterwards wins at once.
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 8'd50, 16'h7777);
      $display("wrsat %0d: wrdy=%b we=%b addr=%0d", c, cfg_wr_ready, mem_we, mem_addr);
      chk("wrsat_wrdy", 100 + c, 32'(cfg_wr_ready), 32'd1);
      chk("wrsat_we",   100 + c, 32'(mem_we),       32'd1);
    end
    drive(1'b0, 1'b0, 4'h1, 32'h32, 1'b1, 8'd50, 16'h7777);
    $display("wrsat 6: rdy=%h wrdy=%b addr=%0d", req_ready, cfg_wr_ready, mem_addr);
    chk("wrsat_rd_rdy",  106, 32'(req_ready),    32'h1);
    chk("wrsat_rd_wrdy", 106, 32'(cfg_wr_ready), 32'd0);
    chk("wrsat_rd_addr", 106, 32'(mem_addr),     32'd50);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 8'h0, 16'h0);
    $display("wrsat 7: rspv=%h rdata=%h", rsp_valid, rsp_data);
    chk("wrsat_rspv",  107, 32'(rsp_valid), 32'h1);
    chk("wrsat_rdata", 107, 32'(rsp_data),  32'h7777);

    // Sparse requesters: pointer at 1 must skip to 3, then wrap to 0.
    drive(1'b0, 1'b0, 4'h9, 32'h03000003, 1'b0, 8'h0, 16'h0);
    $display("rrskip 0: rdy=%h addr=%0d", req_ready, mem_addr);
    chk("rrskip_first", 110, 32'(req_ready), 32'h8);
    drive(1'b0, 1'b0, 4'h9, 32'h03000003, 1'b0, 8'h0, 16'h0);
    $display("rrskip 1: rdy=%h rspv=%h rdata=%h", req_ready, rsp_valid, rsp_data);
    chk("rrskip_wrap",  111, 32'(req_ready), 32'h1);
    chk("rrskip_rspv",  111, 32'(rsp_valid), 32'h8);
    chk("rrskip_rdata", 111, 32'(rsp_data),  32'hA003);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 8'h0, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
